// File: rtl/bsg_counter_underflow_reload_en.sv
`default_nettype none
// ============================================================================
// Module   : bsg_counter_underflow_reload_en
// Purpose  : Loadable down-counter with enable and automatic reload. Writing
//            a value with set_i loads both the live count and the reload
//            register. Each enabled cycle decrements. An enabled cycle that
//            finds the count at zero emits a one-cycle underflow pulse. In
//            the default (periodic) build it also reloads the count.
//            With BSG_COUNTER_UNDERFLOW_RELOAD_ONESHOT_EN defined, the
//            counter instead parks at zero in a DONE state until the next
//            set_i.
// Ports    : clk_i        - clock, rising edge
//            reset_i      - asynchronous active-high reset
//            en_i         - decrement enable (honoured only while running)
//            set_i        - load val_i into count and reload (beats en_i)
//            val_i        - load value, width_p bits, unsigned
//            count_o      - current count (registered)
//            underflow_o  - registered one-cycle underflow/reload pulse
//            running_o    - high while the counter is in RUN
// Macro    : BSG_COUNTER_UNDERFLOW_RELOAD_ONESHOT_EN selects the one-shot build
// Revision : 1.0 - initial release
// ============================================================================
module bsg_counter_underflow_reload_en #(
  parameter int width_p = 24
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               set_i,
  input  logic [width_p-1:0] val_i,
  output logic [width_p-1:0] count_o,
  output logic               underflow_o,
  output logic               running_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1
`ifdef BSG_COUNTER_UNDERFLOW_RELOAD_ONESHOT_EN
    ,
    S_DONE = 2'd2
`endif
  } state_e;

  state_e             r_state;
  state_e             w_state_n;
  logic [width_p-1:0] r_count;
  logic [width_p-1:0] w_count_n;
  logic [width_p-1:0] r_reload;
  logic [width_p-1:0] w_reload_n;
  logic               r_underflow;
  logic               w_underflow_n;

  // State register: every output is taken straight from here, so there is
  // no combinational path from any input to any output.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_reload    <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_count     <= w_count_n;
      r_reload    <= w_reload_n;
      r_underflow <= w_underflow_n;
    end
  end

  // Next-state logic. The underflow pulse defaults low so it can only stay
  // high across cycles when the zero condition genuinely recurs (reload 0).
  always_comb begin
    w_state_n     = r_state;
    w_count_n     = r_count;
    w_reload_n    = r_reload;
    w_underflow_n = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (set_i) begin
          w_count_n  = val_i;
          w_reload_n = val_i;
          w_state_n  = S_RUN;
        end
      end

      S_RUN: begin
        if (set_i) begin
          // A load wins over a coincident underflow and suppresses the pulse.
          w_count_n  = val_i;
          w_reload_n = val_i;
        end else if (en_i) begin
          if (r_count != '0) begin
            w_count_n = r_count - width_p'(1);
          end else begin
            // Zero case never wraps: it either reloads or parks at zero.
            w_underflow_n = 1'b1;
`ifdef BSG_COUNTER_UNDERFLOW_RELOAD_ONESHOT_EN
            w_state_n     = S_DONE;
`else
            w_count_n     = r_reload;
`endif
          end
        end
      end

`ifdef BSG_COUNTER_UNDERFLOW_RELOAD_ONESHOT_EN
      S_DONE: begin
        if (set_i) begin
          w_count_n  = val_i;
          w_reload_n = val_i;
          w_state_n  = S_RUN;
        end
      end
`endif

      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign count_o     = r_count;
  assign underflow_o = r_underflow;
  assign running_o   = (r_state == S_RUN);

endmodule
`default_nettype wire
